// File: rtl/asic_port_host_if.sv
// Host-side chip data port bundle: upstream config/write/read-back streams
// plus the SPI-style wires to and from the chip.
interface asic_port_host_if #(
  parameter int PORT_WIDTH = 128
);
  logic                  cfg_val;
  logic [PORT_WIDTH-1:0] cfg_data;
  logic                  cfg_rdy;
  logic                  wr_val;
  logic [PORT_WIDTH-1:0] wr_data;
  logic                  wr_rdy;
  logic                  rd_val;
  logic [PORT_WIDTH-1:0] rd_data;
  logic                  rd_rdy;
  logic                  I_spi_cs_n;
  logic [PORT_WIDTH-1:0] I_spi_data;
  logic [PORT_WIDTH-1:0] O_spi_data;
  logic                  O_config_req;
  logic                  O_near_full;
  logic                  O_switch_rdwr;
  logic                  cfg_done;
  logic                  rx_ovf;

  // Host port controller view
  modport master (
    input  cfg_val, cfg_data, wr_val, wr_data, rd_rdy,
    input  O_spi_data, O_config_req, O_near_full, O_switch_rdwr,
    output cfg_rdy, wr_rdy, rd_val, rd_data,
    output I_spi_cs_n, I_spi_data, cfg_done, rx_ovf
  );

  // Upstream sources / chip model view
  modport slave (
    output cfg_val, cfg_data, wr_val, wr_data, rd_rdy,
    output O_spi_data, O_config_req, O_near_full, O_switch_rdwr,
    input  cfg_rdy, wr_rdy, rd_val, rd_data,
    input  I_spi_cs_n, I_spi_data, cfg_done, rx_ovf
  );
endinterface

// File: rtl/asic_port_host.sv
// Host end of the chip SPI-style data port: arbitrates config bursts, write
// bursts and read-back into a show-ahead RX FIFO.
//
// state  | meaning
// IDLE   | bus parked (cs_n=1), picks next phase by priority
// CFG    | sending a config burst, never interrupted
// WR     | sending write beats until burst limit or a stop condition
// TURN_R | bus turnaround before the chip drives
// RD     | chip drives, words captured into the RX FIFO
// TURN_W | bus turnaround back to host driving
module asic_port_host #(
  parameter int PORT_WIDTH      = 128,
  parameter int FIFO_ADDR_WIDTH = 6,
  parameter int CFG_WORDS       = 4,
  parameter int MAX_WR_BURST    = 16,
  parameter int TURN_CYC        = 2
) (
  input logic              clk,
  input logic              rst,
  asic_port_host_if.master bus
);
  localparam int DEPTH    = 1 << FIFO_ADDR_WIDTH;
  localparam int PTR_W    = FIFO_ADDR_WIDTH + 1;
  localparam int BEAT_MAX = (CFG_WORDS > MAX_WR_BURST) ? CFG_WORDS : MAX_WR_BURST;
  localparam int BW       = $clog2(BEAT_MAX + 1);
  localparam int TW       = $clog2(TURN_CYC + 1);

  typedef enum logic [2:0] {IDLE, CFG, WR, TURN_R, RD, TURN_W} state_t;

  state_t                state;
  logic                  cs_n_q;
  logic [PORT_WIDTH-1:0] data_q;
  logic                  cfg_done_q;
  logic                  rx_ovf_q;
  logic [BW-1:0]         beat_cnt;
  logic [TW-1:0]         turn_cnt;

  logic [PORT_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      fill;
  logic [PTR_W-1:0]      fill_nxt;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  pop;
  logic                  capture;
  logic                  push;
  logic                  ovf;
  logic                  rd_pause;
  logic                  cfg_beat;
  logic                  wr_beat;
  logic                  wr_exit;
  logic [BW-1:0]         wr_cnt_nxt;

  assign fill       = wr_ptr - rd_ptr;
  assign fifo_full  = (fill == PTR_W'(DEPTH));
  assign fifo_empty = (fill == '0);
  assign pop        = !fifo_empty && bus.rd_rdy;
  assign capture    = (state == RD) && !cs_n_q && bus.O_switch_rdwr;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push       = capture && (!fifo_full || pop);
  assign ovf        = capture && fifo_full && !pop;
  assign fill_nxt   = fill + PTR_W'(push) - PTR_W'(pop);
  // Pause decision looks at occupancy after this cycle's push/pop so the
  // two-slot margin covers words already in flight.
  assign rd_pause   = (fill_nxt >= PTR_W'(DEPTH - 2));

  assign cfg_beat   = (state == CFG) && bus.cfg_val;
  assign wr_beat    = (state == WR) && bus.wr_val && !bus.O_near_full;
  assign wr_cnt_nxt = beat_cnt + BW'(wr_beat);
  assign wr_exit    = (wr_cnt_nxt == BW'(MAX_WR_BURST)) || !bus.wr_val || bus.O_near_full ||
                      bus.O_config_req || bus.O_switch_rdwr;

  assign bus.cfg_rdy    = (state == CFG);
  assign bus.wr_rdy     = (state == WR) && !bus.O_near_full;
  assign bus.rd_val     = !fifo_empty;
  assign bus.rd_data    = mem[rd_ptr[FIFO_ADDR_WIDTH-1:0]];
  assign bus.I_spi_cs_n = cs_n_q;
  assign bus.I_spi_data = data_q;
  assign bus.cfg_done   = cfg_done_q;
  assign bus.rx_ovf     = rx_ovf_q;

  // Phase sequencing and registered bus outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cs_n_q     <= 1'b1;
      data_q     <= '0;
      cfg_done_q <= 1'b0;
      rx_ovf_q   <= 1'b0;
      beat_cnt   <= '0;
      turn_cnt   <= '0;
    end else begin
      cfg_done_q <= 1'b0;
      if (ovf) rx_ovf_q <= 1'b1;
      case (state)
        IDLE: begin
          cs_n_q   <= 1'b1;
          beat_cnt <= '0;
          if (bus.O_config_req) begin
            state <= CFG;
          end else if (bus.O_switch_rdwr) begin
            state    <= TURN_R;
            turn_cnt <= TW'(TURN_CYC - 1);
          end else if (bus.wr_val && !bus.O_near_full) begin
            state <= WR;
          end
        end
        CFG: begin
          if (cfg_beat) begin
            cs_n_q <= 1'b0;
            data_q <= bus.cfg_data;
            if (beat_cnt == BW'(CFG_WORDS - 1)) begin
              state      <= IDLE;
              cfg_done_q <= 1'b1;
              beat_cnt   <= '0;
            end else begin
              beat_cnt <= beat_cnt + BW'(1);
            end
          end else begin
            cs_n_q <= 1'b1;
          end
        end
        WR: begin
          if (wr_beat) begin
            cs_n_q <= 1'b0;
            data_q <= bus.wr_data;
          end else begin
            cs_n_q <= 1'b1;
          end
          if (wr_exit) begin
            state    <= IDLE;
            beat_cnt <= '0;
          end else begin
            beat_cnt <= wr_cnt_nxt;
          end
        end
        TURN_R: begin
          if (turn_cnt == '0) begin
            state  <= RD;
            cs_n_q <= rd_pause;
          end else begin
            turn_cnt <= turn_cnt - TW'(1);
            cs_n_q   <= 1'b1;
          end
        end
        RD: begin
          if (!bus.O_switch_rdwr) begin
            state    <= TURN_W;
            turn_cnt <= TW'(TURN_CYC - 1);
            cs_n_q   <= 1'b1;
          end else begin
            cs_n_q <= rd_pause;
          end
        end
        TURN_W: begin
          cs_n_q <= 1'b1;
          if (turn_cnt == '0) state <= IDLE;
          else turn_cnt <= turn_cnt - TW'(1);
        end
        default: begin
          state  <= IDLE;
          cs_n_q <= 1'b1;
        end
      endcase
    end
  end

  // RX FIFO pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // RX FIFO storage
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[FIFO_ADDR_WIDTH-1:0]] <= bus.O_spi_data;
  end
endmodule

// File: tb/tb_asic_port_host.sv
// Directed bench for asic_port_host: config, write bursts, backpressure,
// read-back, RX overflow, priority and mid-burst reset.
module tb_asic_port_host;
  logic clk = 1'b0;
  logic rst;

  asic_port_host_if #(.PORT_WIDTH(128)) bus ();

  asic_port_host #(
    .PORT_WIDTH(128), .FIFO_ADDR_WIDTH(6), .CFG_WORDS(4), .MAX_WR_BURST(16), .TURN_CYC(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int cfg_idx = 0;
  int wr_idx = 0;
  int wr_limit = 0;
  int spi_ctr = 0;
  int rx_pops = 0;
  bit tx_mon = 0;
  bit rx_mon = 0;
  bit exp_ovf = 0;
  bit cfg_acc;
  bit wr_acc;
  logic [127:0] tx_q[$];
  int tx_cyc[$];
  logic [127:0] rx_model[$];
  logic [127:0] head;

  task automatic chkw(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  // One clock: note handshakes before the edge, then advance the sources.
  task automatic step();
    @(negedge clk);
    cfg_acc = bus.cfg_val && bus.cfg_rdy;
    wr_acc  = bus.wr_val && bus.wr_rdy;
    @(posedge clk);
    #1;
    if (cfg_acc) begin
      cfg_idx++;
      bus.cfg_data = 128'(cfg_idx);
    end
    if (wr_acc) begin
      wr_idx++;
      bus.wr_data = 128'(32'h1000 + wr_idx);
      if (wr_idx == wr_limit) bus.wr_val = 1'b0;
    end
    spi_ctr++;
    bus.O_spi_data = 128'(32'hA000 + spi_ctr);
  endtask

  // Bus monitor and RX FIFO reference model, sampled mid-cycle.
  always @(negedge clk) begin
    if (tx_mon && !bus.I_spi_cs_n) begin
      tx_q.push_back(bus.I_spi_data);
      tx_cyc.push_back(cyc);
    end
    if (rx_mon) begin
      if (bus.rd_rdy && rx_model.size() > 0) begin
        head = rx_model.pop_front();
        chk1("rd_val", bus.rd_val, 1'b1);
        chkw("rd_data", bus.rd_data, head);
        rx_pops++;
      end
      if (!bus.I_spi_cs_n && bus.O_switch_rdwr) begin
        if (rx_model.size() < 64) rx_model.push_back(bus.O_spi_data);
        else exp_ovf = 1'b1;
      end
    end
    cyc++;
  end

  initial begin
    rst = 1'b1;
    bus.cfg_val = 1'b0;
    bus.cfg_data = '0;
    bus.wr_val = 1'b0;
    bus.wr_data = '0;
    bus.rd_rdy = 1'b0;
    bus.O_spi_data = '0;
    bus.O_config_req = 1'b0;
    bus.O_near_full = 1'b0;
    bus.O_switch_rdwr = 1'b0;
    repeat (3) step();
    chk1("rst_cs_n", bus.I_spi_cs_n, 1'b1);
    chkw("rst_data", bus.I_spi_data, 128'h0);
    chk1("rst_cfg_rdy", bus.cfg_rdy, 1'b0);
    chk1("rst_wr_rdy", bus.wr_rdy, 1'b0);
    chk1("rst_rd_val", bus.rd_val, 1'b0);
    chk1("rst_cfg_done", bus.cfg_done, 1'b0);
    chk1("rst_rx_ovf", bus.rx_ovf, 1'b0);
    rst = 1'b0;
    step();

    // Config burst of four words
    tx_q.delete();
    tx_cyc.delete();
    tx_mon = 1'b1;
    cfg_idx = 1;
    bus.cfg_data = 128'h1;
    bus.cfg_val = 1'b1;
    bus.O_config_req = 1'b1;
    step();
    bus.O_config_req = 1'b0;
    chk1("cfg_rdy_in_cfg", bus.cfg_rdy, 1'b1);
    chk1("cfg_cs_idle_before", bus.I_spi_cs_n, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk1("cfg_cs_n", bus.I_spi_cs_n, 1'b0);
      chkw("cfg_word", bus.I_spi_data, 128'(i));
      chk1("cfg_done", bus.cfg_done, i == 4);
    end
    chk1("cfg_rdy_after", bus.cfg_rdy, 1'b0);
    step();
    bus.cfg_val = 1'b0;
    chk1("cfg_cs_after", bus.I_spi_cs_n, 1'b1);
    chk1("cfg_done_clear", bus.cfg_done, 1'b0);
    step();
    chkw("cfg_word_total", 128'(tx_q.size()), 128'd4);

    // Write of 20 words: 16-beat burst, gap, then 4
    tx_q.delete();
    tx_cyc.delete();
    wr_idx = 0;
    wr_limit = 20;
    bus.wr_data = 128'(32'h1000);
    bus.wr_val = 1'b1;
    for (int i = 0; i < 60 && tx_q.size() < 20; i++) step();
    repeat (3) step();
    chkw("wr_count", 128'(tx_q.size()), 128'd20);
    for (int i = 0; i < 20; i++)
      chkw("wr_word", (i < tx_q.size()) ? tx_q[i] : 128'hx, 128'(32'h1000 + i));
    if (tx_cyc.size() == 20) begin
      chkw("wr_burst_contig", 128'(tx_cyc[15] - tx_cyc[0]), 128'd15);
      chk1("wr_burst_gap", (tx_cyc[16] - tx_cyc[15]) >= 2, 1'b1);
    end else begin
      chkw("wr_cyc_count", 128'(tx_cyc.size()), 128'd20);
    end

    // Backpressure at beat 5
    tx_q.delete();
    wr_idx = 0;
    wr_limit = 8;
    bus.wr_data = 128'(32'h1000);
    bus.wr_val = 1'b1;
    for (int i = 0; i < 20 && wr_idx < 5; i++) step();
    bus.O_near_full = 1'b1;
    #1;
    chk1("bp_wr_rdy", bus.wr_rdy, 1'b0);
    repeat (5) step();
    chkw("bp_words_held", 128'(tx_q.size()), 128'd5);
    chk1("bp_cs_n", bus.I_spi_cs_n, 1'b1);
    bus.O_near_full = 1'b0;
    for (int i = 0; i < 20 && wr_idx < 8; i++) step();
    repeat (3) step();
    chkw("bp_words_total", 128'(tx_q.size()), 128'd8);
    for (int i = 0; i < 8; i++)
      chkw("bp_word", (i < tx_q.size()) ? tx_q[i] : 128'hx, 128'(32'h1000 + i));
    tx_mon = 1'b0;

    // Read phase, switch high 10 cycles, consumer always ready
    rx_model.delete();
    rx_pops = 0;
    rx_mon = 1'b1;
    bus.rd_rdy = 1'b1;
    bus.O_switch_rdwr = 1'b1;
    step();
    chk1("turn_r_cs_1", bus.I_spi_cs_n, 1'b1);
    step();
    chk1("turn_r_cs_2", bus.I_spi_cs_n, 1'b1);
    step();
    chk1("rd_cs_active", bus.I_spi_cs_n, 1'b0);
    repeat (7) step();
    bus.O_switch_rdwr = 1'b0;
    step();
    chk1("turn_w_cs", bus.I_spi_cs_n, 1'b1);
    repeat (5) step();
    chkw("rd_pops", 128'(rx_pops), 128'd7);
    chk1("rd_val_empty", bus.rd_val, 1'b0);
    chk1("rd_no_ovf", bus.rx_ovf, 1'b0);

    // RX FIFO fill, pause margin, forced overflow
    rx_model.delete();
    rx_pops = 0;
    bus.rd_rdy = 1'b0;
    bus.O_switch_rdwr = 1'b1;
    repeat (70) step();
    chkw("full_words", 128'(rx_model.size()), 128'd62);
    chk1("full_pause_cs", bus.I_spi_cs_n, 1'b1);
    chk1("full_no_ovf", bus.rx_ovf, 1'b0);
    chk1("full_rd_val", bus.rd_val, 1'b1);
    force dut.cs_n_q = 1'b0;
    step();
    step();
    chkw("forced_words", 128'(rx_model.size()), 128'd64);
    chk1("at_full_no_ovf", bus.rx_ovf, 1'b0);
    step();
    chk1("ovf_set", bus.rx_ovf, 1'b1);
    chk1("ovf_model", bus.rx_ovf, exp_ovf);
    release dut.cs_n_q;
    repeat (2) step();
    chk1("ovf_pause_cs", bus.I_spi_cs_n, 1'b1);
    bus.O_switch_rdwr = 1'b0;
    repeat (4) step();
    chk1("ovf_sticky", bus.rx_ovf, 1'b1);
    bus.rd_rdy = 1'b1;
    repeat (66) step();
    chkw("drain_pops", 128'(rx_pops), 128'd64);
    chk1("drain_empty", bus.rd_val, 1'b0);
    rx_mon = 1'b0;
    bus.rd_rdy = 1'b0;

    // Config beats read-switch on the same cycle; reset mid-burst
    cfg_idx = 32'h11;
    bus.cfg_data = 128'h11;
    bus.cfg_val = 1'b1;
    bus.O_config_req = 1'b1;
    bus.O_switch_rdwr = 1'b1;
    step();
    bus.O_config_req = 1'b0;
    chk1("prio_cfg_rdy", bus.cfg_rdy, 1'b1);
    step();
    chk1("prio_beat1_cs", bus.I_spi_cs_n, 1'b0);
    chkw("prio_beat1", bus.I_spi_data, 128'h11);
    step();
    chkw("prio_beat2", bus.I_spi_data, 128'h12);
    chk1("prio_still_cfg", bus.cfg_rdy, 1'b1);
    rst = 1'b1;
    step();
    chk1("mid_rst_cs_n", bus.I_spi_cs_n, 1'b1);
    chk1("mid_rst_cfg_rdy", bus.cfg_rdy, 1'b0);
    chkw("mid_rst_data", bus.I_spi_data, 128'h0);
    chk1("mid_rst_ovf", bus.rx_ovf, 1'b0);
    chk1("mid_rst_done", bus.cfg_done, 1'b0);
    rst = 1'b0;
    step();
    chk1("no_resume_cfg_rdy", bus.cfg_rdy, 1'b0);
    chk1("no_resume_cs", bus.I_spi_cs_n, 1'b1);
    bus.O_switch_rdwr = 1'b0;
    bus.cfg_val = 1'b0;
    repeat (8) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
